// File: rtl/cisr_row_decoder.sv
// CISR row decoder: accepts per-channel row lengths, hands out global row IDs
// in CISR order (lower channel index first within a cycle) and returns one
// row ID per consumed non-zero element, with a last-of-row flag.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               synchronous clear for a new matrix
//   row_len_in/valid    per-channel row-length push (ready = FIFO not full)
//   row_len_ready       per-channel FIFO not full (combinational)
//   elem_valid          per-channel element consumed this cycle
//   spm_fetch_stall     freezes element processing (pushes still accepted)
//   row_id_out/valid    registered row ID of each accepted element
//   row_last            element is the last of its row
//   rows_assigned       next global row ID to hand out
//   err_underflow       sticky: element arrived with no row available
//   err_zero_len        sticky: zero-length row pushed
module cisr_row_decoder #(
  parameter int unsigned SPM_ELE_W      = 32,
  parameter int unsigned CHAN_NUM       = 16,
  parameter int unsigned LEN_FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CHAN_NUM-1:0][SPM_ELE_W-1:0]   row_len_in,
  input  logic [CHAN_NUM-1:0]                  row_len_valid,
  output logic [CHAN_NUM-1:0]                  row_len_ready,
  input  logic [CHAN_NUM-1:0]                  elem_valid,
  input  logic                                 spm_fetch_stall,
  output logic [CHAN_NUM-1:0][SPM_ELE_W-1:0]   row_id_out,
  output logic [CHAN_NUM-1:0]                  row_id_valid,
  output logic [CHAN_NUM-1:0]                  row_last,
  output logic [SPM_ELE_W-1:0]                 rows_assigned,
  output logic                                 err_underflow,
  output logic                                 err_zero_len
);

  localparam int unsigned AW = $clog2(LEN_FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [CHAN_NUM-1:0][LEN_FIFO_DEPTH-1:0][SPM_ELE_W-1:0] mem_q, mem_d;
  logic [CHAN_NUM-1:0][PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CHAN_NUM-1:0][PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CHAN_NUM-1:0][SPM_ELE_W-1:0] remain_q, remain_d;
  logic [CHAN_NUM-1:0][SPM_ELE_W-1:0] cur_id_q, cur_id_d;
  logic [CHAN_NUM-1:0][SPM_ELE_W-1:0] row_id_out_q, row_id_out_d;
  logic [CHAN_NUM-1:0]                row_id_valid_q, row_id_valid_d;
  logic [CHAN_NUM-1:0]                row_last_q, row_last_d;
  logic [SPM_ELE_W-1:0]               rows_assigned_q, rows_assigned_d;
  logic                               err_underflow_q, err_underflow_d;
  logic                               err_zero_len_q, err_zero_len_d;

  logic [CHAN_NUM-1:0] full;
  logic [CHAN_NUM-1:0] empty;
  logic [SPM_ELE_W-1:0] rank;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned i = 0; i < CHAN_NUM; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    remain_d        = remain_q;
    cur_id_d        = cur_id_q;
    row_id_out_d    = row_id_out_q;
    row_id_valid_d  = '0;
    row_last_d      = '0;
    err_underflow_d = err_underflow_q;
    err_zero_len_d  = err_zero_len_q;
    rank            = '0;

    for (int unsigned i = 0; i < CHAN_NUM; i++) begin
      if (elem_valid[i] && !spm_fetch_stall) begin
        if (remain_q[i] != '0) begin
          row_id_out_d[i]   = cur_id_q[i];
          row_id_valid_d[i] = 1'b1;
          row_last_d[i]     = (remain_q[i] == SPM_ELE_W'(1));
          remain_d[i]       = remain_q[i] - SPM_ELE_W'(1);
        end else if (!empty[i]) begin
          // rank counts pops on lower-index channels earlier in this loop
          row_id_out_d[i]   = rows_assigned_q + rank;
          row_id_valid_d[i] = 1'b1;
          row_last_d[i]     = (mem_q[i][rd_ptr_q[i][AW-1:0]] == SPM_ELE_W'(1));
          cur_id_d[i]       = rows_assigned_q + rank;
          remain_d[i]       = mem_q[i][rd_ptr_q[i][AW-1:0]] - SPM_ELE_W'(1);
          rd_ptr_d[i]       = rd_ptr_q[i] + PW'(1);
          rank              = rank + SPM_ELE_W'(1);
        end else begin
          err_underflow_d = 1'b1;
        end
      end

      // Fullness is judged before this cycle's pop: no pass-through.
      if (row_len_valid[i] && !full[i]) begin
        if (row_len_in[i] == '0) begin
          err_zero_len_d = 1'b1;
        end else begin
          mem_d[i][wr_ptr_q[i][AW-1:0]] = row_len_in[i];
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        end
      end
    end

    rows_assigned_d = rows_assigned_q + rank;

    if (start) begin
      mem_d           = '0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      remain_d        = '0;
      cur_id_d        = '0;
      row_id_out_d    = '0;
      row_id_valid_d  = '0;
      row_last_d      = '0;
      rows_assigned_d = '0;
      err_underflow_d = 1'b0;
      err_zero_len_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      remain_q        <= '0;
      cur_id_q        <= '0;
      row_id_out_q    <= '0;
      row_id_valid_q  <= '0;
      row_last_q      <= '0;
      rows_assigned_q <= '0;
      err_underflow_q <= 1'b0;
      err_zero_len_q  <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      remain_q        <= remain_d;
      cur_id_q        <= cur_id_d;
      row_id_out_q    <= row_id_out_d;
      row_id_valid_q  <= row_id_valid_d;
      row_last_q      <= row_last_d;
      rows_assigned_q <= rows_assigned_d;
      err_underflow_q <= err_underflow_d;
      err_zero_len_q  <= err_zero_len_d;
    end
  end

  assign row_len_ready = ~full;
  assign row_id_out    = row_id_out_q;
  assign row_id_valid  = row_id_valid_q;
  assign row_last      = row_last_q;
  assign rows_assigned = rows_assigned_q;
  assign err_underflow = err_underflow_q;
  assign err_zero_len  = err_zero_len_q;

endmodule
